video_timing_gen: RTL and testbench

Parametrised raster timing generator for the VGA output path. It replaces the fixed-mode hsync/vsync timer. The block runs entirely on the pixel-domain clock, with no sync-derived clocks. It adds a pixel clock-enable, per-signal sync polarity, zero-based active-area coordinates and line/frame strobes, and (optionally) runtime mode switching applied at frame boundaries. It sits between the pixel clock source and the framebuffer reader / DAC output stage.

---
 rtl/video_timing_gen.sv | 162 ++++++++++++++++
 tb/tb_video_timing_gen.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator running on the pixel clock with clock-enable.
// Optional runtime mode switching at frame boundaries: VTG_PROG_EN.
module video_timing_gen #(
   parameter int HACTIVE = 800,
   parameter int HSYNC   = 80,
   parameter int HFP     = 32,
   parameter int HBP     = 112,
   parameter int VACTIVE = 600,
   parameter int VSYNC   = 4,
   parameter int VFP     = 3,
   parameter int VBP     = 17,
   parameter int XW      = 12,
   parameter int YW      = 11,
   parameter bit HS_POL  = 1'b1,
   parameter bit VS_POL  = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
`ifdef VTG_PROG_EN
   input  logic [XW-1:0] cfg_hactive,
   input  logic [XW-1:0] cfg_hsync,
   input  logic [XW-1:0] cfg_hfp,
   input  logic [XW-1:0] cfg_hbp,
   input  logic [YW-1:0] cfg_vactive,
   input  logic [YW-1:0] cfg_vsync,
   input  logic [YW-1:0] cfg_vfp,
   input  logic [YW-1:0] cfg_vbp,
   input  logic          cfg_valid,
   output logic          cfg_ready,
`endif
   output logic          hsync,
   output logic          vsync,
   output logic          de,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          line_start,
   output logic          frame_start
);

   localparam logic [XW-1:0] P_HA = XW'(HACTIVE);
   localparam logic [XW-1:0] P_HS = XW'(HSYNC);
   localparam logic [XW-1:0] P_HF = XW'(HFP);
   localparam logic [XW-1:0] P_HB = XW'(HBP);
   localparam logic [YW-1:0] P_VA = YW'(VACTIVE);
   localparam logic [YW-1:0] P_VS = YW'(VSYNC);
   localparam logic [YW-1:0] P_VF = YW'(VFP);
   localparam logic [YW-1:0] P_VB = YW'(VBP);

   logic [XW-1:0] ha, hs, hf, hb;
   logic [YW-1:0] va, vs, vf, vb;
   logic [XW:0]   h_as, h_ae, h_tot;
   logic [YW:0]   v_as, v_ae, v_tot;
   logic [XW-1:0] h_cnt_q, h_cnt_d;
   logic [YW-1:0] v_cnt_q, v_cnt_d;
   logic          h_last, v_last, h_act, v_act;
   logic          hsync_q, hsync_d, vsync_q, vsync_d;
   logic          de_q, de_d, ls_q, ls_d, fs_q, fs_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;

`ifdef VTG_PROG_EN
   logic [XW-1:0] ha_q, hs_q, hf_q, hb_q;
   logic [XW-1:0] sha_q, shs_q, shf_q, shb_q;
   logic [YW-1:0] va_q, vs_q, vf_q, vb_q;
   logic [YW-1:0] sva_q, svs_q, svf_q, svb_q;
   logic          rdy_q, take, swap;

   assign take = cfg_valid & rdy_q;
   // Shadow full implies no handshake can land on the swap edge
   assign swap = en & h_last & v_last & ~rdy_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ha_q  <= P_HA; hs_q  <= P_HS; hf_q  <= P_HF; hb_q  <= P_HB;
         va_q  <= P_VA; vs_q  <= P_VS; vf_q  <= P_VF; vb_q  <= P_VB;
         sha_q <= '0;   shs_q <= '0;   shf_q <= '0;   shb_q <= '0;
         sva_q <= '0;   svs_q <= '0;   svf_q <= '0;   svb_q <= '0;
         rdy_q <= 1'b1;
      end else begin
         if (swap) begin
            ha_q  <= sha_q; hs_q <= shs_q; hf_q <= shf_q; hb_q <= shb_q;
            va_q  <= sva_q; vs_q <= svs_q; vf_q <= svf_q; vb_q <= svb_q;
            rdy_q <= 1'b1;
         end
         if (take) begin
            sha_q <= cfg_hactive; shs_q <= cfg_hsync;
            shf_q <= cfg_hfp;     shb_q <= cfg_hbp;
            sva_q <= cfg_vactive; svs_q <= cfg_vsync;
            svf_q <= cfg_vfp;     svb_q <= cfg_vbp;
            rdy_q <= 1'b0;
         end
      end
   end

   assign ha = ha_q; assign hs = hs_q; assign hf = hf_q; assign hb = hb_q;
   assign va = va_q; assign vs = vs_q; assign vf = vf_q; assign vb = vb_q;
   assign cfg_ready = rdy_q;
`else
   assign ha = P_HA; assign hs = P_HS; assign hf = P_HF; assign hb = P_HB;
   assign va = P_VA; assign vs = P_VS; assign vf = P_VF; assign vb = P_VB;
`endif

   assign h_as  = {1'b0, hs} + {1'b0, hb};
   assign h_ae  = h_as + {1'b0, ha};
   assign h_tot = h_ae + {1'b0, hf};
   assign v_as  = {1'b0, vs} + {1'b0, vb};
   assign v_ae  = v_as + {1'b0, va};
   assign v_tot = v_ae + {1'b0, vf};

   assign h_last = ({1'b0, h_cnt_q} == h_tot - (XW+1)'(1));
   assign v_last = ({1'b0, v_cnt_q} == v_tot - (YW+1)'(1));

   always_comb begin
      h_cnt_d = h_last ? '0 : h_cnt_q + XW'(1);
      v_cnt_d = v_cnt_q;
      if (h_last) v_cnt_d = v_last ? '0 : v_cnt_q + YW'(1);
      h_act   = ({1'b0, h_cnt_q} >= h_as) && ({1'b0, h_cnt_q} < h_ae);
      v_act   = ({1'b0, v_cnt_q} >= v_as) && ({1'b0, v_cnt_q} < v_ae);
      hsync_d = (h_cnt_q < hs) ? HS_POL : ~HS_POL;
      vsync_d = (v_cnt_q < vs) ? VS_POL : ~VS_POL;
      de_d    = h_act & v_act;
      x_d     = de_d ? h_cnt_q - h_as[XW-1:0] : '0;
      y_d     = de_d ? v_cnt_q - v_as[YW-1:0] : '0;
      ls_d    = (h_cnt_q == '0);
      fs_d    = ls_d && (v_cnt_q == '0);
   end

   // Outputs carry the decode of the counter value current at the edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         hsync_q <= ~HS_POL;
         vsync_q <= ~VS_POL;
         de_q    <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         ls_q    <= 1'b0;
         fs_q    <= 1'b0;
      end else if (en) begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         de_q    <= de_d;
         x_q     <= x_d;
         y_q     <= y_d;
         ls_q    <= ls_d;
         fs_q    <= fs_d;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign x           = x_q;
   assign y           = y_q;
   assign line_start  = ls_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: frame-position model plus directed checks.
// Builds with or without VTG_PROG_EN.
module tb_video_timing_gen;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        de;
      logic [11:0] x;
      logic [10:0] y;
      logic        ls;
      logic        fs;
   } out_t;

   typedef struct {
      int ha; int hs; int hf; int hb;
      int va; int vs; int vf; int vb;
   } mode_t;

   logic        clk = 1'b0;
   logic        rst, en;
   logic [11:0] cfg_hactive, cfg_hsync, cfg_hfp, cfg_hbp;
   logic [10:0] cfg_vactive, cfg_vsync, cfg_vfp, cfg_vbp;
   logic        cfg_valid;
   logic        hsync, vsync, de, line_start, frame_start;
   logic [11:0] x;
   logic [10:0] y;
   logic        hsync_n, vsync_n, de_n, ls_n, fs_n;
   logic [11:0] x_n;
   logic [10:0] y_n;
   logic        rdy_act, rdy_n;
   logic [27:0] act_v;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_on = 0;

   always #5 clk = ~clk;

   video_timing_gen #(
      .HACTIVE(4), .HSYNC(2), .HFP(1), .HBP(1),
      .VACTIVE(3), .VSYNC(1), .VFP(1), .VBP(1),
      .XW(12), .YW(11), .HS_POL(1'b1), .VS_POL(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .en(en),
`ifdef VTG_PROG_EN
      .cfg_hactive(cfg_hactive), .cfg_hsync(cfg_hsync),
      .cfg_hfp(cfg_hfp), .cfg_hbp(cfg_hbp),
      .cfg_vactive(cfg_vactive), .cfg_vsync(cfg_vsync),
      .cfg_vfp(cfg_vfp), .cfg_vbp(cfg_vbp),
      .cfg_valid(cfg_valid), .cfg_ready(rdy_act),
`endif
      .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
      .line_start(line_start), .frame_start(frame_start)
   );

   video_timing_gen #(
      .HACTIVE(4), .HSYNC(2), .HFP(1), .HBP(1),
      .VACTIVE(3), .VSYNC(1), .VFP(1), .VBP(1),
      .XW(12), .YW(11), .HS_POL(1'b0), .VS_POL(1'b0)
   ) dut_n (
      .clk(clk), .rst(rst), .en(en),
`ifdef VTG_PROG_EN
      .cfg_hactive(cfg_hactive), .cfg_hsync(cfg_hsync),
      .cfg_hfp(cfg_hfp), .cfg_hbp(cfg_hbp),
      .cfg_vactive(cfg_vactive), .cfg_vsync(cfg_vsync),
      .cfg_vfp(cfg_vfp), .cfg_vbp(cfg_vbp),
      .cfg_valid(cfg_valid), .cfg_ready(rdy_n),
`endif
      .hsync(hsync_n), .vsync(vsync_n), .de(de_n), .x(x_n), .y(y_n),
      .line_start(ls_n), .frame_start(fs_n)
   );

`ifndef VTG_PROG_EN
   assign rdy_act = 1'b1;
   assign rdy_n   = 1'b1;
`endif

   assign act_v = {hsync, vsync, de, x, y, line_start, frame_start};

   // Model: position within the frame and the mode that frame runs in
   int    fp;
   mode_t mode, shd;
   bit    pend, rdy;
   out_t  exp_o;

   function automatic int per(mode_t m);
      return (m.hs + m.hb + m.ha + m.hf) * (m.vs + m.vb + m.va + m.vf);
   endfunction

   function automatic out_t calc(int pos, mode_t m);
      out_t o;
      int ht, h, v, h0, v0;
      ht   = m.hs + m.hb + m.ha + m.hf;
      h    = pos % ht;
      v    = pos / ht;
      h0   = m.hs + m.hb;
      v0   = m.vs + m.vb;
      o.hs = (h < m.hs);
      o.vs = (v < m.vs);
      o.de = (h >= h0) && (h < h0 + m.ha) && (v >= v0) && (v < v0 + m.va);
      o.x  = o.de ? 12'(h - h0) : 12'd0;
      o.y  = o.de ? 11'(v - v0) : 11'd0;
      o.ls = (h == 0);
      o.fs = (pos == 0);
      return o;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         exp_o <= '0;
         fp    <= 0;
         mode  <= '{4, 2, 1, 1, 3, 1, 1, 1};
         shd   <= '{0, 0, 0, 0, 0, 0, 0, 0};
         pend  <= 1'b0;
         rdy   <= 1'b1;
      end else begin
         if (en) begin
            exp_o <= calc(fp, mode);
            if (fp == per(mode) - 1) begin
               fp <= 0;
               if (pend) begin
                  mode <= shd;
                  pend <= 1'b0;
                  rdy  <= 1'b1;
               end
            end else begin
               fp <= fp + 1;
            end
         end
         if (cfg_valid && rdy) begin
            shd  <= '{int'(cfg_hactive), int'(cfg_hsync),
                      int'(cfg_hfp), int'(cfg_hbp),
                      int'(cfg_vactive), int'(cfg_vsync),
                      int'(cfg_vfp), int'(cfg_vbp)};
            pend <= 1'b1;
            rdy  <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         n_cmp++;
         if (act_v !== exp_o || hsync_n !== ~exp_o.hs ||
             vsync_n !== ~exp_o.vs || de_n !== exp_o.de ||
             x_n !== exp_o.x || y_n !== exp_o.y ||
             ls_n !== exp_o.ls || fs_n !== exp_o.fs ||
             rdy_act !== rdy || rdy_n !== rdy) begin
            n_bad++;
            $display("FAIL model t=%0t act=%h/%b%b/%b exp=%h/%b",
                     $time, act_v, hsync_n, vsync_n, rdy_act, exp_o, rdy);
         end
      end
   end

   task automatic chk(string nm, int act, int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
      end
   endtask

   task automatic tick(bit e);
      en = e;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   logic [7:0]  hs_lit;
   logic [27:0] prev_v;
   int p, h, v, dcnt, last_fs, en_cnt, n, xmax, fs_cnt;
   bit found;

   initial begin
      rst = 1'b0; en = 1'b0; cfg_valid = 1'b0;
      cfg_hactive = 12'd4; cfg_hsync = 12'd2; cfg_hfp = 12'd1; cfg_hbp = 12'd1;
      cfg_vactive = 11'd3; cfg_vsync = 11'd1; cfg_vfp = 11'd1; cfg_vbp = 11'd1;
      hs_lit = 8'b1100_0000;
      chk_on = 1'b1;
      repeat (3) tick(1'b0);
      chk("rst_hsync", 32'(hsync), 0);
      chk("rst_vsync", 32'(vsync), 0);
      chk("rst_de", 32'(de), 0);
      chk("rst_hsync_n", 32'(hsync_n), 1);
      chk("rst_vsync_n", 32'(vsync_n), 1);
      chk("rst_ready", 32'(rdy_act), 1);
      rst = 1'b1;

      dcnt = 0; last_fs = 0;
      for (int k = 1; k <= 97; k++) begin
         tick(1'b1);
         p = (k - 1) % 48; h = p % 8; v = p / 8;
         if (k <= 8) begin
            chk("line0_hsync", 32'(hsync), 32'(hs_lit[8-k]));
            chk("line0_vsync", 32'(vsync), 1);
            chk("line0_de", 32'(de), 0);
         end
         if (k == 1) chk("first_fs", 32'(frame_start), 1);
         if (k <= 48 && de) dcnt++;
         if (k == 48) chk("de_per_frame", dcnt, 12);
         if (frame_start) begin
            if (last_fs > 0) chk("fs_period", k - last_fs, 48);
            last_fs = k;
         end
         if (v == 2) begin
            chk("line2_de", 32'(de), 32'(h >= 3 && h <= 6));
            if (h >= 3 && h <= 6) chk("line2_x", 32'(x), h - 3);
         end
         if (h == 4 && v >= 2 && v <= 4) chk("row_y", 32'(y), v - 2);
      end

      en_cnt = 0; last_fs = -1;
      for (int i = 0; i < 440; i++) begin
         prev_v = act_v;
         tick(i % 4 == 1 || i % 4 == 2 ? 1'b0 : 1'b1);
         if (!en) begin
            if (act_v !== prev_v) begin
               n_bad++;
               $display("FAIL hold act=%h exp=%h", act_v, prev_v);
            end
            n_cmp++;
         end else begin
            en_cnt++;
            if (frame_start) begin
               if (last_fs >= 0) chk("en_fs_period", en_cnt - last_fs, 48);
               last_fs = en_cnt;
            end
         end
      end

      rst = 1'b0;
      tick(1'b0);
      rst = 1'b1;
      repeat (29) tick(1'b1);
      chk("pre_rst_de", 32'(de), 1);
      chk("pre_rst_x", 32'(x), 1);
      chk("pre_rst_y", 32'(y), 1);
      #2 rst = 1'b0;
      #1;
      chk("arst_de", 32'(de), 0);
      chk("arst_xy", 32'(x) + 32'(y), 0);
      chk("arst_hsync", 32'(hsync), 0);
      chk("arst_hsync_n", 32'(hsync_n), 1);
      chk("arst_strobes", 32'(line_start) + 32'(frame_start), 0);
      @(negedge clk);
      rst = 1'b1;
      tick(1'b1);
      chk("restart_fs", 32'(frame_start), 1);
      chk("restart_ls", 32'(line_start), 1);
      chk("restart_sync", 32'(hsync) + 32'(vsync), 2);

`ifdef VTG_PROG_EN
      repeat (9) tick(1'b1);
      cfg_hactive = 12'd8;
      cfg_valid = 1'b1;
      tick(1'b1);
      cfg_valid = 1'b0;
      chk("cfg_rdy_low", 32'(rdy_act), 0);
      found = 1'b0; n = 0;
      for (int k = 1; k <= 200 && !found; k++) begin
         tick(1'b1);
         n = k;
         if (rdy_act) found = 1'b1;
      end
      chk("cfg_swap_seen", 32'(found), 1);
      chk("cfg_rdy_wait", n, 37);
      dcnt = 0; xmax = 0; fs_cnt = 0;
      for (int k = 1; k <= 72; k++) begin
         tick(1'b1);
         if (k == 1) begin
            chk("new_fs", 32'(frame_start), 1);
            chk("new_rdy", 32'(rdy_act), 1);
         end
         if (frame_start) fs_cnt++;
         if (de) dcnt++;
         if (de && int'(x) > xmax) xmax = int'(x);
      end
      chk("new_de_frame", dcnt, 24);
      chk("new_xmax", xmax, 7);
      chk("new_fs_once", fs_cnt, 1);
      tick(1'b1);
      chk("new_period", 32'(frame_start), 1);
`endif

      chk_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
